// File: rtl/regbank_pkg.sv
// ---------------------------------------------------------------------------
// regbank_pkg
// Shared defaults and types for the register-bank write arbiter.
//   DEFAULT_ADDR_BITS    : register address width (bank depth 2**ADDR_BITS)
//   DEFAULT_WORD_WIDE    : data word width
//   DEFAULT_STARVE_LIMIT : consecutive dbg wait cycles that force a dbg grant
//   state_t              : arbiter FSM states (IDLE, CLEAR)
// ---------------------------------------------------------------------------
package regbank_pkg;

   localparam int DEFAULT_ADDR_BITS    = 5;
   localparam int DEFAULT_WORD_WIDE    = 32;
   localparam int DEFAULT_STARVE_LIMIT = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// regbank_write_arbiter
// Merges pipeline writeback and debug/loader writes into one registered bank
// write port, and can sweep the whole bank to zero on request.
//
// Ports:
//   clock, reset              : sole clock; asynchronous active-low reset
//   wb_valid/addr/data/ready  : pipeline writeback request channel
//   dbg_valid/addr/data/ready : debug/loader write request channel
//   clear_req                 : start a zero-sweep of the whole bank
//   busy                      : high while the sweep runs (state CLEAR)
//   clear_done                : one-cycle pulse after the last sweep write
//   regWrite/writeReg/writeData : registered bank write port
//   stateDbg                  : current FSM state, for observation
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. ready is combinational from the current state and inputs,
// never depends on itself, and the requester may hold valid for as long as it
// likes; an accepted transfer appears on the bank port for the whole next
// cycle. Writes to register 0 complete the handshake but never reach the bank.
// ---------------------------------------------------------------------------
module regbank_write_arbiter
   import regbank_pkg::*;
#(
   parameter int ADDR_BITS    = DEFAULT_ADDR_BITS,
   parameter int WORD_WIDE    = DEFAULT_WORD_WIDE,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 wb_valid,
   input  logic [ADDR_BITS-1:0] wb_addr,
   input  logic [WORD_WIDE-1:0] wb_data,
   output logic                 wb_ready,
   input  logic                 dbg_valid,
   input  logic [ADDR_BITS-1:0] dbg_addr,
   input  logic [WORD_WIDE-1:0] dbg_data,
   output logic                 dbg_ready,
   input  logic                 clear_req,
   output logic                 busy,
   output logic                 clear_done,
   output logic                 regWrite,
   output logic [ADDR_BITS-1:0] writeReg,
   output logic [WORD_WIDE-1:0] writeData,
   output state_t               stateDbg
);

   localparam int STARVE_BITS = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_BITS-1:0]   LAST_ADDR  = '1;
   localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);

   state_t                 state, stateNext;
   logic [ADDR_BITS-1:0]   sweepCount;
   logic [STARVE_BITS-1:0] starveCount;
   logic                   starved;
   logic                   wbXfer, dbgXfer;
   logic [ADDR_BITS-1:0]   selAddr;
   logic [WORD_WIDE-1:0]   selData;

   assign starved  = (starveCount == STARVE_MAX);
   assign wbXfer   = wb_valid & wb_ready;
   assign dbgXfer  = dbg_valid & dbg_ready;
   assign busy     = (state == CLEAR);
   assign stateDbg = state;

   // Only one channel can be ready-and-valid in a cycle, so a plain mux
   // selects the winning request.
   assign selAddr = wbXfer ? wb_addr : dbg_addr;
   assign selData = wbXfer ? wb_data : dbg_data;

   // Next state and grants. wb normally wins; a dbg requester that has waited
   // STARVE_LIMIT cycles takes the port for one cycle instead.
   always_comb begin
      stateNext = state;
      wb_ready  = 1'b0;
      dbg_ready = 1'b0;
      case (state)
         IDLE: begin
            if (clear_req) begin
               stateNext = CLEAR;
            end else if (starved) begin
               dbg_ready = 1'b1;
            end else begin
               wb_ready  = 1'b1;
               dbg_ready = !wb_valid;
            end
         end
         CLEAR: begin
            if (sweepCount == LAST_ADDR) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNext;
   end

   // Sweep counter sits at 0 in IDLE so every sweep starts from register 0;
   // it wraps back to 0 on the last sweep cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)              sweepCount <= '0;
      else if (state == IDLE)  sweepCount <= '0;
      else                     sweepCount <= sweepCount + ADDR_BITS'(1);
   end

   // Starvation counter: counts IDLE cycles a dbg request waits, saturating.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         starveCount <= '0;
      end else if (!dbg_valid || dbgXfer) begin
         starveCount <= '0;
      end else if (state == IDLE && !starved) begin
         starveCount <= starveCount + STARVE_BITS'(1);
      end
   end

   // Registered bank port. Accepted writes to register 0 are dropped and
   // leave writeReg/writeData holding their previous values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         regWrite  <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (state == CLEAR) begin
         regWrite  <= 1'b1;
         writeReg  <= sweepCount;
         writeData <= '0;
      end else if ((wbXfer || dbgXfer) && (selAddr != '0)) begin
         regWrite  <= 1'b1;
         writeReg  <= selAddr;
         writeData <= selData;
      end else begin
         regWrite  <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) clear_done <= 1'b0;
      else        clear_done <= (state == CLEAR) && (sweepCount == LAST_ADDR);
   end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regbank_write_arbiter
// Directed bench for regbank_write_arbiter. The driver issues requests and
// pushes each expected bank write into exp_q; the monitor pops and compares
// whenever regWrite is high, and keeps a copy of the bank written by the DUT.
// ---------------------------------------------------------------------------
module tb_regbank_write_arbiter;
   import regbank_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clock;
   logic          reset;
   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_ready;
   logic          dbg_valid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;
   logic          dbg_ready;
   logic          clear_req;
   logic          busy;
   logic          clear_done;
   logic          regWrite;
   logic [AW-1:0] writeReg;
   logic [DW-1:0] writeData;
   state_t        stateDbg;

   logic [AW+DW-1:0] exp_q[$];
   logic [DW-1:0]    bank[DEPTH];
   logic [DW-1:0]    exp_bank[DEPTH];
   int checks;
   int failures;
   int busy_cycles;
   int done_pulses;

   regbank_write_arbiter #(
      .ADDR_BITS(AW),
      .WORD_WIDE(DW),
      .STARVE_LIMIT(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .wb_valid(wb_valid),
      .wb_addr(wb_addr),
      .wb_data(wb_data),
      .wb_ready(wb_ready),
      .dbg_valid(dbg_valid),
      .dbg_addr(dbg_addr),
      .dbg_data(dbg_data),
      .dbg_ready(dbg_ready),
      .clear_req(clear_req),
      .busy(busy),
      .clear_done(clear_done),
      .regWrite(regWrite),
      .writeReg(writeReg),
      .writeData(writeData),
      .stateDbg(stateDbg)
   );

   // ---------------- clock / watchdog ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         if (busy) busy_cycles++;
         if (clear_done) done_pulses++;
         if (regWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", writeReg, writeData);
            end else begin
               logic [AW+DW-1:0] e;
               e = exp_q.pop_front();
               if ({writeReg, writeData} !== e) begin
                  failures++;
                  $display("FAIL bank_write: got addr=%0d data=%h expected addr=%0d data=%h",
                           writeReg, writeData, e[AW+DW-1:DW], e[DW-1:0]);
               end
            end
            bank[writeReg] = writeData;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // One cycle of stimulus: inputs change just after the rising edge, grants
   // are checked on the falling edge, the transfer happens on the next edge.
   task automatic drive(input logic wbv, input logic [AW-1:0] wba, input logic [DW-1:0] wbd,
                        input logic dbv, input logic [AW-1:0] dba, input logic [DW-1:0] dbd,
                        input logic clr, input logic exp_wbr, input logic exp_dbr,
                        input string name);
      wb_valid  = wbv;  wb_addr  = wba; wb_data  = wbd;
      dbg_valid = dbv;  dbg_addr = dba; dbg_data = dbd;
      clear_req = clr;
      @(negedge clock);
      check({name, "_wb_ready"}, DW'(wb_ready), DW'(exp_wbr));
      check({name, "_dbg_ready"}, DW'(dbg_ready), DW'(exp_dbr));
      if (wbv && exp_wbr && wba != 0) begin
         exp_q.push_back({wba, wbd});
         exp_bank[wba] = wbd;
      end
      if (dbv && exp_dbr && dba != 0) begin
         exp_q.push_back({dba, dbd});
         exp_bank[dba] = dbd;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input string name);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, name);
   endtask

   task automatic wait_cycles(input int n);
      wb_valid = 1'b0; dbg_valid = 1'b0; clear_req = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check_bank(input string name);
      for (int i = 0; i < DEPTH; i++) check($sformatf("%s_reg%0d", name, i), bank[i], exp_bank[i]);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0; failures = 0; busy_cycles = 0; done_pulses = 0;
      for (int i = 0; i < DEPTH; i++) begin
         bank[i] = '0;
         exp_bank[i] = '0;
      end
      reset = 1'b0;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
      clear_req = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_regWrite", DW'(regWrite), 32'd0);
      check("rst_writeReg", DW'(writeReg), 32'd0);
      check("rst_writeData", writeData, 32'd0);
      check("rst_busy", DW'(busy), 32'd0);
      check("rst_clear_done", DW'(clear_done), 32'd0);
      check("rst_state", DW'(stateDbg), DW'(IDLE));
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Single writeback on the first edge after release
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "wb5");
      idle("wb5_idle");
      check("wb5_bank", bank[5], 32'hDEADBEEF);

      // wb beats dbg, dbg follows once wb drops
      drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, 1'b0, "pri_both");
      drive(1'b0, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, 1'b1, "pri_dbg");
      idle("pri_idle");
      check("pri_bank3", bank[3], 32'h0000_0033);

      // Starvation: 8 waiting cycles, forced dbg grant on the 9th
      for (int i = 0; i < 8; i++)
         drive(1'b1, AW'(10 + i), DW'(32'hA0 + i), 1'b1, 5'd7, 32'h0000C0DE, 1'b0, 1'b1, 1'b0,
               $sformatf("starve_wait%0d", i));
      drive(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd7, 32'h0000C0DE, 1'b0, 1'b0, 1'b1, "starve_grant");
      drive(1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd8, 32'hC0DE0002, 1'b0, 1'b1, 1'b0, "starve_reset");
      idle("starve_idle");
      check("starve_bank7", bank[7], 32'h0000C0DE);

      // Writes to register 0 handshake but never reach the bank
      drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_0001, 1'b0, 1'b1, 1'b1, "dbg_r0");
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "wb_r0");
      idle("r0_idle");
      check("r0_bank", bank[0], 32'd0);

      // Load registers 1..31, then sweep; a second clear_req mid-sweep is ignored
      for (int i = 1; i < DEPTH; i++)
         drive(1'b1, AW'(i), DW'(32'h5A00_0000 | i), 1'b0, '0, '0, 1'b0, 1'b1, 1'b0,
               $sformatf("load%0d", i));
      idle("load_idle");
      check_bank("loaded");
      busy_cycles = 0;
      done_pulses = 0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "clr_req");
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back({AW'(i), DW'(0)});
         exp_bank[i] = '0;
      end
      for (int k = 0; k < DEPTH; k++)
         drive(1'b1, 5'd9, 32'h0000_0BAD, 1'b0, '0, '0, (k == 10), 1'b0, 1'b0,
               $sformatf("clr_cnt%0d", k));
      wb_valid = 1'b0; clear_req = 1'b0;
      @(negedge clock);
      check("clr_done_now", DW'(clear_done), 32'd1);
      check("clr_busy_low", DW'(busy), 32'd0);
      @(posedge clock);
      #1;
      idle("clr_after");
      wait_cycles(3);
      check("clr_busy_cycles", DW'(busy_cycles), 32'd32);
      check("clr_done_pulses", DW'(done_pulses), 32'd1);
      check("clr_queue_empty", DW'(exp_q.size()), 32'd0);
      check_bank("cleared");

      // Reset in the middle of a sweep abandons it
      done_pulses = 0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "abort_req");
      for (int i = 0; i < 19; i++) exp_q.push_back({AW'(i), DW'(0)});
      for (int k = 0; k < 20; k++)
         drive(1'b0, '0, '0, 1'b0, '0, '0, (k == 10), 1'b0, 1'b0, $sformatf("abort_cnt%0d", k));
      reset = 1'b0;
      check("abort_queue_drained", DW'(exp_q.size()), 32'd0);
      @(negedge clock);
      check("abort_busy", DW'(busy), 32'd0);
      check("abort_regWrite", DW'(regWrite), 32'd0);
      check("abort_state", DW'(stateDbg), DW'(IDLE));
      @(posedge clock);
      #1;
      reset = 1'b1;
      drive(1'b1, 5'd12, 32'h1234_5678, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "abort_wb");
      wait_cycles(40);
      check("abort_no_done", DW'(done_pulses), 32'd0);
      check("abort_bank12", bank[12], 32'h1234_5678);
      check("final_queue_empty", DW'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
